// File: rtl/engine_set_ops_merge_kernel_pkg.sv
`default_nettype none
// ============================================================================
// Module   : engine_set_ops_merge_kernel_pkg
// Brief    : Shared types for the sorted-list set-operation merge kernel.
// Revision : 1.0 - initial release
// ============================================================================
package engine_set_ops_merge_kernel_pkg;

    localparam int c_SET_OPERATION_W = 2;

    typedef enum logic [c_SET_OPERATION_W-1:0] {
        SET_OP_INTERSECT  = 2'd0,
        SET_OP_UNION      = 2'd1,
        SET_OP_DIFFERENCE = 2'd2,
        SET_OP_RESERVED   = 2'd3
    } type_set_operation;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_MERGE   = 3'd1,
        ST_DRAIN_A = 3'd2,
        ST_DRAIN_B = 3'd3,
        ST_TERM    = 3'd4,
        ST_DONE    = 3'd5
    } type_merge_state;

    // Reserved code falls through to the intersect rules.
    function automatic logic emits_a_only(input type_set_operation op);
        return (op == SET_OP_UNION) || (op == SET_OP_DIFFERENCE);
    endfunction

    function automatic logic emits_b_only(input type_set_operation op);
        return (op == SET_OP_UNION);
    endfunction

    function automatic logic emits_common(input type_set_operation op);
        return (op != SET_OP_DIFFERENCE);
    endfunction

endpackage
`default_nettype wire

// File: rtl/engine_set_ops_merge_output_reg.sv
`default_nettype none
// ============================================================================
// Module   : engine_set_ops_merge_output_reg
// Brief    : Single-entry output register; beat held stable until accepted.
// Revision : 1.0 - initial release
// ============================================================================
module engine_set_ops_merge_output_reg
    import engine_set_ops_merge_kernel_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  load_i,
    input  logic [DATA_WIDTH-1:0] load_data_i,
    input  logic                  load_last_i,
    input  logic                  out_ready_i,
    output logic                  slot_free_o,
    output logic                  out_valid_o,
    output logic [DATA_WIDTH-1:0] out_data_o,
    output logic                  out_last_o
);

    logic                  valid_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  last_q;

    assign slot_free_o = !valid_q || out_ready_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            last_q  <= 1'b0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            data_q  <= load_data_i;
            last_q  <= load_last_i;
        end else if (out_ready_i) begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end
    end

    assign out_valid_o = valid_q;
    assign out_data_o  = data_q;
    assign out_last_o  = last_q;

endmodule
`default_nettype wire

// File: rtl/engine_set_ops_merge_kernel.sv
`default_nettype none
// ============================================================================
// Module   : engine_set_ops_merge_kernel
// Brief    : Merges two sorted lists into INTERSECT / UNION / DIFFERENCE plus a
//            count terminator. Optional macro SET_OPS_MERGE_KERNEL_STATS_EN
//            enables the compare-step counter.
// Revision : 1.0 - initial release
// ============================================================================
module engine_set_ops_merge_kernel
    import engine_set_ops_merge_kernel_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ID_ENGINE  = 0
) (
    input  logic                  ap_clk,
    input  logic                  areset,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    input  logic [1:0]            cfg_set_operation,
    input  logic                  a_valid,
    output logic                  a_ready,
    input  logic [DATA_WIDTH-1:0] a_data,
    input  logic                  a_last,
    input  logic                  a_null,
    input  logic                  b_valid,
    output logic                  b_ready,
    input  logic [DATA_WIDTH-1:0] b_data,
    input  logic                  b_last,
    input  logic                  b_null,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    output logic                  done,
    output logic [31:0]           stat_compare_count
);

    if (DATA_WIDTH < 1 || ID_ENGINE < 0) begin : g_param_check
        $error("engine_set_ops_merge_kernel: illegal DATA_WIDTH or ID_ENGINE");
    end

    type_merge_state       state_q, state_d;
    type_set_operation     op_q;
    logic [DATA_WIDTH-1:0] count_q;
    logic                  term_sent_q, term_sent_d;
    logic                  done_q, done_d;

    logic                  a_hv_q, a_hl_q, a_hn_q, a_got_last_q;
    logic [DATA_WIDTH-1:0] a_hd_q;
    logic                  b_hv_q, b_hl_q, b_hn_q, b_got_last_q;
    logic [DATA_WIDTH-1:0] b_hd_q;

    logic                  a_pop, b_pop, a_ready_int, b_ready_int, a_fetch, b_fetch;
    logic                  load, load_last, slot_free, heads_real, cmp_step, cfg_accept;
    logic [DATA_WIDTH-1:0] load_data;

    // Inputs land in head registers so readiness never looks at the peer's valid.
    assign cfg_accept  = (state_q == ST_IDLE) && cfg_valid;
    assign cfg_ready   = (state_q == ST_IDLE) && !areset;
    assign heads_real  = a_hv_q && !a_hn_q && b_hv_q && !b_hn_q;
    assign cmp_step    = (state_q == ST_MERGE) && heads_real && slot_free;
    assign a_ready_int = ((state_q == ST_MERGE) || (state_q == ST_DRAIN_A)) &&
                         !a_got_last_q && (!a_hv_q || a_pop);
    assign b_ready_int = ((state_q == ST_MERGE) || (state_q == ST_DRAIN_B)) &&
                         !b_got_last_q && (!b_hv_q || b_pop);
    assign a_ready     = a_ready_int && !areset;
    assign b_ready     = b_ready_int && !areset;
    assign a_fetch     = a_ready && a_valid;
    assign b_fetch     = b_ready && b_valid;
    assign done        = done_q;

    always_comb begin
        state_d     = state_q;
        a_pop       = 1'b0;
        b_pop       = 1'b0;
        load        = 1'b0;
        load_last   = 1'b0;
        load_data   = a_hd_q;
        done_d      = 1'b0;
        term_sent_d = term_sent_q;
        case (state_q)
            ST_IDLE: begin
                term_sent_d = 1'b0;
                if (cfg_valid) state_d = ST_MERGE;
            end
            ST_MERGE: begin
                if (a_hv_q && a_hn_q) a_pop = 1'b1;
                if (b_hv_q && b_hn_q) b_pop = 1'b1;
                if (cmp_step) begin
                    if (a_hd_q < b_hd_q) begin
                        a_pop = 1'b1;
                        load  = emits_a_only(op_q);
                    end else if (a_hd_q > b_hd_q) begin
                        b_pop     = 1'b1;
                        load      = emits_b_only(op_q);
                        load_data = b_hd_q;
                    end else begin
                        a_pop = 1'b1;
                        b_pop = 1'b1;
                        load  = emits_common(op_q);
                    end
                end
                if (a_pop && a_hl_q && b_pop && b_hl_q) state_d = ST_TERM;
                else if (a_pop && a_hl_q)               state_d = ST_DRAIN_B;
                else if (b_pop && b_hl_q)               state_d = ST_DRAIN_A;
            end
            ST_DRAIN_A: begin
                if (a_hv_q && (a_hn_q || slot_free)) begin
                    a_pop = 1'b1;
                    load  = !a_hn_q && emits_a_only(op_q);
                    if (a_hl_q) state_d = ST_TERM;
                end
            end
            ST_DRAIN_B: begin
                if (b_hv_q && (b_hn_q || slot_free)) begin
                    b_pop     = 1'b1;
                    load      = !b_hn_q && emits_b_only(op_q);
                    load_data = b_hd_q;
                    if (b_hl_q) state_d = ST_TERM;
                end
            end
            ST_TERM: begin
                if (!term_sent_q) begin
                    if (slot_free) begin
                        load        = 1'b1;
                        load_last   = 1'b1;
                        load_data   = count_q;
                        term_sent_d = 1'b1;
                    end
                end else if (out_valid && out_ready && out_last) begin
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge ap_clk) begin
        if (areset) begin
            state_q      <= ST_IDLE;
            op_q         <= SET_OP_INTERSECT;
            count_q      <= '0;
            term_sent_q  <= 1'b0;
            done_q       <= 1'b0;
            a_hv_q       <= 1'b0;
            a_hd_q       <= '0;
            a_hl_q       <= 1'b0;
            a_hn_q       <= 1'b0;
            a_got_last_q <= 1'b0;
            b_hv_q       <= 1'b0;
            b_hd_q       <= '0;
            b_hl_q       <= 1'b0;
            b_hn_q       <= 1'b0;
            b_got_last_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            term_sent_q <= term_sent_d;
            done_q      <= done_d;
            if (cfg_accept) begin
                op_q    <= type_set_operation'(cfg_set_operation);
                count_q <= '0;
            end else if (load && !load_last && (count_q != '1)) begin
                count_q <= count_q + 1'b1;
            end

            if (a_fetch) begin
                a_hv_q <= 1'b1;
                a_hd_q <= a_data;
                a_hl_q <= a_last;
                a_hn_q <= a_null;
            end else if (a_pop) begin
                a_hv_q <= 1'b0;
            end
            if (cfg_accept)            a_got_last_q <= 1'b0;
            else if (a_fetch && a_last) a_got_last_q <= 1'b1;

            if (b_fetch) begin
                b_hv_q <= 1'b1;
                b_hd_q <= b_data;
                b_hl_q <= b_last;
                b_hn_q <= b_null;
            end else if (b_pop) begin
                b_hv_q <= 1'b0;
            end
            if (cfg_accept)            b_got_last_q <= 1'b0;
            else if (b_fetch && b_last) b_got_last_q <= 1'b1;
        end
    end

`ifdef SET_OPS_MERGE_KERNEL_STATS_EN
    logic [31:0] stat_q;
    always_ff @(posedge ap_clk) begin
        if (areset)                             stat_q <= '0;
        else if (cfg_accept)                    stat_q <= '0;
        else if (cmp_step && (stat_q != '1))    stat_q <= stat_q + 32'd1;
    end
    assign stat_compare_count = stat_q;
`else
    assign stat_compare_count = 32'd0;
`endif

    engine_set_ops_merge_output_reg #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_output_reg (
        .clk_i       (ap_clk),
        .rst_i       (areset),
        .load_i      (load),
        .load_data_i (load_data),
        .load_last_i (load_last),
        .out_ready_i (out_ready),
        .slot_free_o (slot_free),
        .out_valid_o (out_valid),
        .out_data_o  (out_data),
        .out_last_o  (out_last)
    );

endmodule
`default_nettype wire

// File: tb/tb_engine_set_ops_merge_kernel.sv
`default_nettype none
// ============================================================================
// Module   : tb_engine_set_ops_merge_kernel
// Brief    : Directed scoreboard bench for the set-operation merge kernel.
// Revision : 1.0 - initial release
// ============================================================================
module tb_engine_set_ops_merge_kernel;

`ifdef SET_OPS_MERGE_KERNEL_STATS_EN
    localparam bit c_STATS_ON = 1'b1;
`else
    localparam bit c_STATS_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        areset = 1'b1;
    logic        cfg_valid = 1'b0, cfg_ready;
    logic [1:0]  cfg_set_operation = 2'd0;
    logic        a_valid = 1'b0, a_ready, a_last = 1'b0, a_null = 1'b0;
    logic [31:0] a_data = '0;
    logic        b_valid = 1'b0, b_ready, b_last = 1'b0, b_null = 1'b0;
    logic [31:0] b_data = '0;
    logic        out_valid, out_ready, out_last, done;
    logic [31:0] out_data, stat_compare_count;

    typedef struct packed {
        logic [31:0] d;
        logic        l;
    } beat_t;

    beat_t       sb[$];
    logic [31:0] qa[$];
    logic [31:0] qb[$];
    int          total = 0, bad = 0;
    int          done_count = 0, acc_count = 0;
    bit          abort = 1'b0, stall_mode = 1'b0;
    bit          prev_stall = 1'b0, prev_done = 1'b0;
    logic [31:0] prev_data = '0;

    always #5 clk = ~clk;

    engine_set_ops_merge_kernel #(
        .DATA_WIDTH (32),
        .ID_ENGINE  (0)
    ) dut (
        .ap_clk             (clk),
        .areset             (areset),
        .cfg_valid          (cfg_valid),
        .cfg_ready          (cfg_ready),
        .cfg_set_operation  (cfg_set_operation),
        .a_valid            (a_valid),
        .a_ready            (a_ready),
        .a_data             (a_data),
        .a_last             (a_last),
        .a_null             (a_null),
        .b_valid            (b_valid),
        .b_ready            (b_ready),
        .b_data             (b_data),
        .b_last             (b_last),
        .b_null             (b_null),
        .out_valid          (out_valid),
        .out_ready          (out_ready),
        .out_data           (out_data),
        .out_last           (out_last),
        .done               (done),
        .stat_compare_count (stat_compare_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Golden set semantics; returns the number of A/B compare steps.
    function automatic int model(input int op, input logic [31:0] a[$], input logic [31:0] b[$]);
        int i = 0, j = 0, cmp = 0, n = 0;
        while (i < a.size() && j < b.size()) begin
            cmp++;
            if (a[i] < b[j]) begin
                if (op == 1 || op == 2) begin sb.push_back('{d: a[i], l: 1'b0}); n++; end
                i++;
            end else if (a[i] > b[j]) begin
                if (op == 1) begin sb.push_back('{d: b[j], l: 1'b0}); n++; end
                j++;
            end else begin
                if (op != 2) begin sb.push_back('{d: a[i], l: 1'b0}); n++; end
                i++;
                j++;
            end
        end
        for (; i < a.size(); i++)
            if (op == 1 || op == 2) begin sb.push_back('{d: a[i], l: 1'b0}); n++; end
        for (; j < b.size(); j++)
            if (op == 1) begin sb.push_back('{d: b[j], l: 1'b0}); n++; end
        sb.push_back('{d: n, l: 1'b1});
        return cmp;
    endfunction

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            out_ready = stall_mode ? ~out_ready : 1'b1;
        end
    end

    always @(negedge clk) begin
        if (areset) begin
            prev_stall = 1'b0;
            prev_done  = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_valid", {31'b0, out_valid}, 32'd1);
                chk("stall_data", out_data, prev_data);
            end
            if (done) chk("done_width", {31'b0, prev_done}, 32'd0);
            if (done) done_count++;
            prev_done = done;
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_beat", {31'b0, out_valid}, 32'd0);
                end else begin
                    beat_t e;
                    e = sb.pop_front();
                    chk("out_data", out_data, e.d);
                    chk("out_last", {31'b0, out_last}, {31'b0, e.l});
                    acc_count++;
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
        end
    end

    task automatic drive(input bit sel, input logic [31:0] v[$], input bit nul);
        int   n, k;
        logic rdy;
        n = nul ? 1 : v.size();
        for (int i = 0; i < n && !abort; i++) begin
            if (sel) begin
                b_valid = 1'b1; b_data = nul ? 32'd0 : v[i]; b_last = (i == n - 1); b_null = nul;
            end else begin
                a_valid = 1'b1; a_data = nul ? 32'd0 : v[i]; a_last = (i == n - 1); a_null = nul;
            end
            k = 0;
            do begin
                @(negedge clk);
                k++;
                rdy = sel ? b_ready : a_ready;
            end while (!rdy && !abort && k < 400);
            if (!abort) begin
                chk(sel ? "b_handshake" : "a_handshake", {31'b0, rdy}, 32'd1);
                @(posedge clk);
                #1;
            end
        end
        if (sel) begin b_valid = 1'b0; b_last = 1'b0; b_null = 1'b0; end
        else     begin a_valid = 1'b0; a_last = 1'b0; a_null = 1'b0; end
    endtask

    task automatic do_cfg(input int op);
        int k = 0;
        cfg_valid = 1'b1;
        cfg_set_operation = op[1:0];
        do begin @(negedge clk); k++; end while (!cfg_ready && k < 100);
        chk("cfg_handshake", {31'b0, cfg_ready}, 32'd1);
        @(posedge clk);
        #1;
        cfg_valid = 1'b0;
    endtask

    task automatic run_op(input string name, input int op, input bit a_nul, input bit b_nul, input bit stall);
        int cmp, base, k;
        cmp  = model(op, qa, qb);
        base = done_count;
        stall_mode = stall;
        do_cfg(op);
        fork
            drive(1'b0, qa, a_nul);
            drive(1'b1, qb, b_nul);
        join
        k = 0;
        while (done_count == base && k < 500) begin @(negedge clk); k++; end
        chk({name, "_done"}, done_count - base, 32'd1);
        chk({name, "_drained"}, sb.size(), 32'd0);
        chk({name, "_stat"}, stat_compare_count, c_STATS_ON ? cmp : 0);
        stall_mode = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        int base, acc_base, k, cmp;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cfg_ready", {31'b0, cfg_ready}, 32'd0);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_a_ready", {31'b0, a_ready}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_stat", stat_compare_count, 32'd0);
        areset = 1'b0;
        @(posedge clk);
        #1;
        chk("idle_cfg_ready", {31'b0, cfg_ready}, 32'd1);
        chk("idle_a_ready", {31'b0, a_ready}, 32'd0);

        qa = {32'd1, 32'd3, 32'd5, 32'd7}; qb = {32'd3, 32'd4, 32'd7};
        run_op("intersect", 0, 1'b0, 1'b0, 1'b0);
        qa = {32'd1, 32'd3}; qb = {32'd2, 32'd3, 32'd9};
        run_op("union", 1, 1'b0, 1'b0, 1'b0);
        qa = {32'd2, 32'd4, 32'd6}; qb = {32'd4};
        run_op("difference", 2, 1'b0, 1'b0, 1'b0);
        qa.delete(); qb = {32'd5, 32'd6};
        run_op("union_null_a", 1, 1'b1, 1'b0, 1'b0);
        qa.delete(); qb = {32'd5, 32'd6};
        run_op("isect_null_a", 0, 1'b1, 1'b0, 1'b0);
        qa = {32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8}; qb = {32'd9};
        run_op("union_stall", 1, 1'b0, 1'b0, 1'b1);
        qa = {32'd1, 32'd2}; qb = {32'd2};
        run_op("reserved_op", 3, 1'b0, 1'b0, 1'b0);

        // Reset lands in the middle of a union after two beats have left.
        qa = {32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6}; qb = {32'd10, 32'd20};
        cmp = model(1, qa, qb);
        base = done_count;
        acc_base = acc_count;
        do_cfg(1);
        fork
            drive(1'b0, qa, 1'b0);
            drive(1'b1, qb, 1'b0);
            begin
                k = 0;
                while (acc_count < acc_base + 2 && k < 200) begin @(posedge clk); k++; end
                chk("pre_reset_beats", acc_count - acc_base, 32'd2);
                #1;
                areset = 1'b1;
                abort  = 1'b1;
            end
        join
        @(posedge clk);
        #1;
        chk("mid_rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("mid_rst_out_data", out_data, 32'd0);
        chk("mid_rst_out_last", {31'b0, out_last}, 32'd0);
        chk("mid_rst_done", {31'b0, done}, 32'd0);
        chk("mid_rst_ready", {30'b0, a_ready, b_ready}, 32'd0);
        chk("mid_rst_cfg_ready", {31'b0, cfg_ready}, 32'd0);
        chk("mid_rst_stat", stat_compare_count, 32'd0);
        areset = 1'b0;
        abort  = 1'b0;
        sb.delete();
        repeat (3) @(posedge clk);
        #1;
        chk("mid_rst_no_done", done_count - base, 32'd0);
        chk("mid_rst_cmp_seen", {31'b0, (cmp > 0)}, 32'd1);

        qa = {32'd5, 32'd7, 32'd9}; qb = {32'd1, 32'd7};
        run_op("post_reset_diff", 2, 1'b0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
